// File: rtl/ttc_pkg.sv
// Shared definitions for the TTC synchronisation controller: state encoding
// and LHC timing constants.
package ttc_pkg;

    // FSM state encoding; codes 6 and 7 are unused and recover to IDLE.
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RESYNC   = 3'd1,
        ST_WAIT_BX0 = 3'd2,
        ST_QUALIFY  = 3'd3,
        ST_LOCKED   = 3'd4,
        ST_FAIL     = 3'd5,
        ST_BAD6     = 3'd6,
        ST_BAD7     = 3'd7
    } state_t;

    // Bunch crossings per LHC orbit.
    localparam int LHC_CYCLE = 3564;

    // Default BX0 watchdog limit: two full orbits.
    localparam int TIMEOUT_CYC_DEF = 2 * LHC_CYCLE;

endpackage

// File: rtl/ttc_bx0_watchdog.sv
// BX0 watchdog: counts cycles since the last BX0 or state entry and flags a
// timeout on the cycle the count reaches TIMEOUT_CYC-1 without a BX0.
module ttc_bx0_watchdog #(
    parameter int WDW         = 13,
    parameter int TIMEOUT_CYC = ttc_pkg::TIMEOUT_CYC_DEF
) (
    input  logic clock,
    input  logic reset,
    input  logic i_clear,
    input  logic i_bx0,
    output logic o_timeout
);

    localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT_CYC - 1);
    localparam logic [WDW-1:0] WD_MAX  = WDW'(TIMEOUT_CYC);

    logic [WDW-1:0] r_cnt;

    // Cycle counter: restarts on clear or BX0, otherwise counts up and holds at the limit.
    always_ff @(posedge clock) begin
        if (reset || i_clear || i_bx0) begin
            r_cnt <= '0;
        end else if (r_cnt != WD_MAX) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // A BX0 arriving in the last allowed cycle still counts as on time.
    assign o_timeout = (r_cnt == WD_LAST) && !i_bx0;

endmodule

// File: rtl/ttc_sync_ctrl.sv
// TTC bunch-counter synchronisation sequencer: resync pulse, wait for BX0,
// qualify lock over consecutive clean BX0s, monitor lock, retry or park in FAIL.
module ttc_sync_ctrl
    import ttc_pkg::*;
#(
    parameter int RESYNC_LEN  = 4,
    parameter int TIMEOUT_CYC = ttc_pkg::TIMEOUT_CYC_DEF,
    parameter int LOCK_BX0    = 16,
    parameter int MAX_RETRY   = 7,
    parameter int MXCNT       = 32,
    parameter int WDW         = 13
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_ttc_bx0,
    input  logic             i_bx0_sync_err,
    input  logic             i_auto_resync_en,
    input  logic             i_sw_resync_req,
    output logic             o_ttc_resync,
    output logic [2:0]       o_state,
    output logic             o_locked,
    output logic             o_sync_fail,
    output logic [3:0]       o_retry_cnt,
    output logic [MXCNT-1:0] o_unlock_cnt
);

    localparam int LENW = $clog2(RESYNC_LEN + 1);
    localparam int GW   = $clog2(LOCK_BX0 + 1);

    localparam logic [LENW-1:0] LEN_LAST   = LENW'(RESYNC_LEN - 1);
    localparam logic [GW-1:0]   GOOD_LAST  = GW'(LOCK_BX0 - 1);
    localparam logic [3:0]      RETRY_LAST = 4'(MAX_RETRY);

    state_t            r_state;
    state_t            w_state_next;
    logic [LENW-1:0]   r_len_cnt;
    logic [LENW-1:0]   w_len_next;
    logic [GW-1:0]     r_good_cnt;
    logic [GW-1:0]     w_good_next;
    logic [3:0]        r_retry_cnt;
    logic [3:0]        w_retry_next;
    logic [MXCNT-1:0]  r_unlock_cnt;
    logic [MXCNT-1:0]  w_unlock_next;
    logic              w_wd_clear;
    logic              w_timeout;

    // Watchdog restarts whenever the FSM moves to a different state.
    assign w_wd_clear = (w_state_next != r_state);

    ttc_bx0_watchdog #(
        .WDW         (WDW),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_watchdog (
        .clock     (clock),
        .reset     (reset),
        .i_clear   (w_wd_clear),
        .i_bx0     (i_ttc_bx0),
        .o_timeout (w_timeout)
    );

    // State and counter registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_len_cnt    <= '0;
            r_good_cnt   <= '0;
            r_retry_cnt  <= '0;
            r_unlock_cnt <= '0;
        end else begin
            r_state      <= w_state_next;
            r_len_cnt    <= w_len_next;
            r_good_cnt   <= w_good_next;
            r_retry_cnt  <= w_retry_next;
            r_unlock_cnt <= w_unlock_next;
        end
    end

    // Next-state and counter update; a software request overrides everything but RESYNC.
    always_comb begin
        w_state_next  = r_state;
        w_len_next    = '0;
        w_good_next   = r_good_cnt;
        w_retry_next  = r_retry_cnt;
        w_unlock_next = r_unlock_cnt;

        if (i_sw_resync_req && (r_state != ST_RESYNC)) begin
            w_state_next = ST_RESYNC;
            w_retry_next = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_auto_resync_en) begin
                        w_state_next = ST_RESYNC;
                    end
                end
                ST_RESYNC: begin
                    if (r_len_cnt == LEN_LAST) begin
                        w_state_next = ST_WAIT_BX0;
                    end else begin
                        w_len_next = r_len_cnt + 1'b1;
                    end
                end
                ST_WAIT_BX0: begin
                    if (w_timeout) begin
                        if (r_retry_cnt == RETRY_LAST) begin
                            w_state_next = ST_FAIL;
                        end else begin
                            w_retry_next = r_retry_cnt + 1'b1;
                            w_state_next = ST_RESYNC;
                        end
                    end else if (i_ttc_bx0) begin
                        w_good_next  = '0;
                        w_state_next = ST_QUALIFY;
                    end
                end
                ST_QUALIFY: begin
                    if (i_bx0_sync_err || w_timeout) begin
                        if (r_retry_cnt == RETRY_LAST) begin
                            w_state_next = ST_FAIL;
                        end else begin
                            w_retry_next = r_retry_cnt + 1'b1;
                            w_state_next = ST_RESYNC;
                        end
                    end else if (i_ttc_bx0) begin
                        if (r_good_cnt == GOOD_LAST) begin
                            w_retry_next = '0;
                            w_state_next = ST_LOCKED;
                        end else begin
                            w_good_next = r_good_cnt + 1'b1;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (i_bx0_sync_err || w_timeout) begin
                        if (r_unlock_cnt != {MXCNT{1'b1}}) begin
                            w_unlock_next = r_unlock_cnt + 1'b1;
                        end
                        w_retry_next = '0;
                        w_state_next = i_auto_resync_en ? ST_RESYNC : ST_FAIL;
                    end
                end
                ST_FAIL: begin
                    w_state_next = ST_FAIL;
                end
                default: begin
                    w_state_next = ST_IDLE;
                end
            endcase
        end
    end

    // Moore outputs decoded straight from the registered state.
    assign o_state      = r_state;
    assign o_ttc_resync = (r_state == ST_RESYNC);
    assign o_locked     = (r_state == ST_LOCKED);
    assign o_sync_fail  = (r_state == ST_FAIL);
    assign o_retry_cnt  = r_retry_cnt;
    assign o_unlock_cnt = r_unlock_cnt;

endmodule
